// File: rtl/mem_port_arbiter.sv
// Shares one MFA/MFC memory port between an instruction-fetch and a load/store requester.
// Serialises transactions, alternates owners under contention and aborts stalled RAM accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              f_MFA,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_MFC,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_MFA,
    input  logic              d_READ_WRITE,
    input  logic              d_WORD_BYTE,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_MFC,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_MFA,
    output logic              mem_READ_WRITE,
    output logic              mem_WORD_BYTE,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_MFC,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE, DRAIN} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              mem_mfa_q, mem_mfa_d;
    logic              mem_rw_q, mem_rw_d;
    logic              mem_wb_q, mem_wb_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              f_mfc_q, f_mfc_d;
    logic              d_mfc_q, d_mfc_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              terr_q, terr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              sel;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            mem_mfa_q   <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_wb_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_mfc_q     <= 1'b0;
            d_mfc_q     <= 1'b0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            terr_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_mfa_q   <= mem_mfa_d;
            mem_rw_q    <= mem_rw_d;
            mem_wb_q    <= mem_wb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            f_mfc_q     <= f_mfc_d;
            d_mfc_q     <= d_mfc_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            terr_q      <= terr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_mfa_d   = mem_mfa_q;
        mem_rw_d    = mem_rw_q;
        mem_wb_d    = mem_wb_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_mfc_d     = f_mfc_q;
        d_mfc_d     = d_mfc_q;
        owner_d     = owner_q;
        last_d      = last_q;
        terr_d      = terr_q;
        cnt_d       = cnt_q;
        // Tie goes to whoever was not served last; a lone request wins outright.
        sel         = (f_MFA && d_MFA) ? ~last_q : d_MFA;
        unique case (state_q)
            IDLE: begin
                if (f_MFA || d_MFA) begin
                    owner_d   = sel;
                    mem_mfa_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = BUSY;
                    if (sel) begin
                        mem_rw_d    = d_READ_WRITE;
                        mem_wb_d    = d_WORD_BYTE;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_rw_d   = 1'b1;
                        mem_wb_d   = 1'b1;
                        mem_addr_d = f_addr;
                    end
                end
            end
            BUSY: begin
                // A completion on the same edge the counter expires still wins.
                if (mem_MFC) begin
                    if (owner_q) d_rdata_d = mem_rdata;
                    else         f_rdata_d = mem_rdata;
                    f_mfc_d   = ~owner_q;
                    d_mfc_d   = owner_q;
                    mem_mfa_d = 1'b0;
                    last_d    = owner_q;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TMO) begin
                        f_mfc_d   = ~owner_q;
                        d_mfc_d   = owner_q;
                        mem_mfa_d = 1'b0;
                        terr_d    = 1'b1;
                        state_d   = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (!(owner_q ? d_MFA : f_MFA) && !mem_MFC) begin
                    f_mfc_d = 1'b0;
                    d_mfc_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign f_MFC          = f_mfc_q;
    assign d_MFC          = d_mfc_q;
    assign f_rdata        = f_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign mem_MFA        = mem_mfa_q;
    assign mem_READ_WRITE = mem_rw_q;
    assign mem_WORD_BYTE  = mem_wb_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign owner          = owner_q;
    assign timeout_err    = terr_q;
endmodule
